// File: rtl/cordic_z_iter_ctrl.sv
// CORDIC Z-path iteration sequencer: feeds +/-atan(2^-i) to an external registered adder, collects direction bits.
// Optional quadrant fold before the first iteration is enabled by defining CORDIC_Z_QUAD_EN.
module cordic_z_iter_ctrl #(
   parameter int N_ITER  = 16,
   parameter int ADD_LAT = 1
) (
   input  logic              C,
   input  logic              RN,
   input  logic              START,
   input  logic [31:0]       Z0,
   output logic              BUSY,
   output logic              DONE,
   output logic [31:0]       Z_OUT,
   output logic              DIR,
   output logic              DIR_V,
   output logic [N_ITER-1:0] DIRS,
   output logic              QFLIP,
   output logic [31:0]       ZA,
   output logic [31:0]       ZB,
   output logic              ZCIN,
   output logic              ZCE,
   input  logic [31:0]       ZS
);

`ifdef CORDIC_Z_QUAD_EN
   typedef enum logic [2:0] {IDLE, PRE, ISSUE, WAIT, FIN} state_t;
   localparam logic [31:0] HALF_PI     = 32'h3243F6A9;
   localparam logic [31:0] NEG_HALF_PI = 32'hCDBC0957;
   localparam logic [31:0] PI          = 32'h6487ED51;
   localparam logic [31:0] NEG_PI      = 32'h9B7812AF;
`else
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
`endif

   state_t state, next_state;

   logic [31:0]       z_reg;
   logic [4:0]        iter;
   logic [1:0]        wcnt;
   logic [N_ITER-1:0] dirs;
   logic [31:0]       z_out;
   logic              qflip;
   logic              d;
   logic              last_wait;
   logic              last_iter;
   logic [31:0]       rom_val;

   // Rounded atan(2^-i) * 2^29; beyond i=9 the cubic term is below half an LSB.
   function automatic logic [31:0] atan_rom(input logic [4:0] idx);
      case (idx)
         5'd0:    atan_rom = 32'h1921FB54;
         5'd1:    atan_rom = 32'h0ED63383;
         5'd2:    atan_rom = 32'h07D6DD7E;
         5'd3:    atan_rom = 32'h03FAB753;
         5'd4:    atan_rom = 32'h01FF55BB;
         5'd5:    atan_rom = 32'h00FFEAAE;
         5'd6:    atan_rom = 32'h007FFD55;
         5'd7:    atan_rom = 32'h003FFFAB;
         5'd8:    atan_rom = 32'h001FFFF5;
         5'd9:    atan_rom = 32'h000FFFFF;
         default: atan_rom = 32'h2000_0000 >> idx;
      endcase
   endfunction

   assign d         = ~z_reg[31];
   assign rom_val   = atan_rom(iter);
   assign last_wait = (wcnt == 2'(ADD_LAT - 1));
   assign last_iter = (iter == 5'(N_ITER - 1));

   assign BUSY  = (state != IDLE);
   assign Z_OUT = z_out;
   assign DIRS  = dirs;
   assign QFLIP = qflip;

   always_ff @(posedge C) begin
      if (!RN) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      DONE  = 1'b0;
      DIR   = 1'b0;
      DIR_V = 1'b0;
      ZA    = 32'd0;
      ZB    = 32'd0;
      ZCIN  = 1'b0;
      ZCE   = 1'b0;
      case (state)
         IDLE: begin
`ifdef CORDIC_Z_QUAD_EN
            if (START) next_state = PRE;
`else
            if (START) next_state = ISSUE;
`endif
         end
`ifdef CORDIC_Z_QUAD_EN
         PRE: next_state = ISSUE;
`endif
         ISSUE: begin
            ZA    = z_reg;
            ZB    = d ? ~rom_val : rom_val;
            ZCIN  = d;
            ZCE   = 1'b1;
            DIR   = d;
            DIR_V = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            // z_reg and iter only move on the last WAIT edge, so the operands stay put.
            ZA   = z_reg;
            ZB   = d ? ~rom_val : rom_val;
            ZCIN = d;
            ZCE  = 1'b1;
            if (last_wait) next_state = last_iter ? FIN : ISSUE;
         end
         FIN: begin
            DONE       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge C) begin
      if (!RN) begin
         z_reg <= 32'd0;
         iter  <= 5'd0;
         wcnt  <= 2'd0;
         dirs  <= '0;
         z_out <= 32'd0;
         qflip <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  z_reg <= Z0;
                  iter  <= 5'd0;
                  wcnt  <= 2'd0;
                  dirs  <= '0;
                  qflip <= 1'b0;
               end
            end
`ifdef CORDIC_Z_QUAD_EN
            PRE: begin
               // One local adder serves both folds: z - pi or z + pi.
               if ($signed(z_reg) > $signed(HALF_PI) || $signed(z_reg) < $signed(NEG_HALF_PI)) begin
                  z_reg <= z_reg + (($signed(z_reg) > $signed(HALF_PI)) ? NEG_PI : PI);
                  qflip <= 1'b1;
               end
            end
`endif
            ISSUE: begin
               wcnt <= 2'd0;
               for (int k = 0; k < N_ITER; k++) begin
                  if (iter == 5'(k)) dirs[k] <= d;
               end
            end
            WAIT: begin
               if (last_wait) begin
                  z_reg <= ZS;
                  iter  <= iter + 5'd1;
                  if (last_iter) z_out <= ZS;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
